// File: rtl/hilo_mdu.sv
// Multiply/divide unit with architectural HI/LO for the EX stage.
// MULT/MULTU/DIV/DIVU run multi-cycle; MTHI/MTLO write in one cycle.
module hilo_mdu #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 34
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] CntZero = '0;
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] MulLast = CntW'(MUL_CYCLES);
    localparam logic [CntW-1:0] DivLast = CntW'(DIV_CYCLES);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            sgn_q, sgn_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     quo_q, quo_d;
    logic [31:0]     dvs_q, dvs_d;

    // Sign-extending only for signed ops lets one 64-bit multiply serve both.
    logic [63:0] ext_a, ext_b, prod;
    assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // One restoring step; rem_q < dvs_q keeps the difference within 32 bits.
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_sub;
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_ge  = rem_sh >= {1'b0, dvs_q};
    assign rem_sub = rem_sh[31:0] - dvs_q;

    logic [31:0] a_mag, b_mag;
    assign a_mag = (sgn_q && a_q[31]) ? -a_q : a_q;
    assign b_mag = (sgn_q && b_q[31]) ? -b_q : b_q;

    logic        neg_quo, neg_rem, div_zero;
    logic [31:0] quo_fix, rem_fix;
    assign neg_quo  = sgn_q & (a_q[31] ^ b_q[31]);
    assign neg_rem  = sgn_q & a_q[31];
    assign div_zero = (b_q == 32'd0);
    assign quo_fix  = div_zero ? 32'hFFFF_FFFF : (neg_quo ? -quo_q : quo_q);
    assign rem_fix  = div_zero ? a_q : (neg_rem ? -rem_q : rem_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    case (op)
                        OpMult, OpMultu: begin
                            state_d = StMul;
                            cnt_d   = CntOne;
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op == OpMult);
                        end
                        OpDiv, OpDivu: begin
                            state_d = StDiv;
                            cnt_d   = CntOne;
                            a_d     = rs_val;
                            b_d     = rt_val;
                            sgn_d   = (op == OpDiv);
                        end
                        OpMthi:  hi_d = rs_val;
                        OpMtlo:  lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end else if (cnt_q == MulLast) begin
                    state_d      = StIdle;
                    cnt_d        = CntZero;
                    {hi_d, lo_d} = prod;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDiv: begin
                if (flush) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                end else if (cnt_q == DivLast) begin
                    state_d = StIdle;
                    cnt_d   = CntZero;
                    hi_d    = rem_fix;
                    lo_d    = quo_fix;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == CntOne) begin
                        // Operand prep: quotient register starts holding the dividend magnitude.
                        rem_d = 32'd0;
                        quo_d = a_mag;
                        dvs_d = b_mag;
                    end else if (rem_ge) begin
                        rem_d = rem_sub;
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = rem_sh[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = CntZero;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign stall = busy & rd_hilo;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule
